// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF)
// and the load/store data port (DM); one non-overlapped transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_wren,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              store_q, store_d;
    logic              memEn_q, memEn_d;
    logic              memWren_q, memWren_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0] dmRdata_q, dmRdata_d;
    logic              ifAck_q, ifAck_d;
    logic              dmAck_q, dmAck_d;
    logic              grantDm;

    // On a conflict the port that was not served last wins.
    assign grantDm = dm_req && (!if_req || (last_q == OWN_IF));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        store_d    = store_q;
        memEn_d    = 1'b0;
        memWren_d  = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        ifRdata_d  = ifRdata_q;
        dmRdata_d  = dmRdata_q;
        ifAck_d    = 1'b0;
        dmAck_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grantDm) begin
                    memAddr_d  = dm_addr;
                    memWdata_d = dm_wdata;
                    memWren_d  = dm_wren;
                    store_d    = dm_wren;
                    owner_d    = OWN_DM;
                    last_d     = OWN_DM;
                    memEn_d    = 1'b1;
                    cnt_d      = 3'(MEM_LAT);
                    state_d    = S_ACCESS;
                end else if (if_req) begin
                    memAddr_d  = if_addr;
                    store_d    = 1'b0;
                    owner_d    = OWN_IF;
                    last_d     = OWN_IF;
                    memEn_d    = 1'b1;
                    cnt_d      = 3'(MEM_LAT);
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - 3'd1;
                // Read data is valid on the last counted edge; stores leave dm_rdata alone.
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_DM) begin
                        dmAck_d = 1'b1;
                        if (!store_q) begin
                            dmRdata_d = mem_rdata;
                        end
                    end else begin
                        ifAck_d   = 1'b1;
                        ifRdata_d = mem_rdata;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            owner_q    <= OWN_IF;
            last_q     <= OWN_IF;
            store_q    <= 1'b0;
            memEn_q    <= 1'b0;
            memWren_q  <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            ifRdata_q  <= '0;
            dmRdata_q  <= '0;
            ifAck_q    <= 1'b0;
            dmAck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            store_q    <= store_d;
            memEn_q    <= memEn_d;
            memWren_q  <= memWren_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            ifRdata_q  <= ifRdata_d;
            dmRdata_q  <= dmRdata_d;
            ifAck_q    <= ifAck_d;
            dmAck_q    <= dmAck_d;
        end
    end

    assign mem_en    = memEn_q;
    assign mem_wren  = memWren_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign if_rdata  = ifRdata_q;
    assign dm_rdata  = dmRdata_q;
    assign if_ack    = ifAck_q;
    assign dm_ack    = dmAck_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory strobes and
// acks into queues that a negedge monitor pops and compares.
module tb_mem_arbiter;

    localparam int MEM_LAT = 2;

    localparam logic [31:0] A_IF0 = 32'h0040_0000;
    localparam logic [31:0] A_IF1 = 32'h0040_0004;
    localparam logic [31:0] A_IF2 = 32'h0040_0008;
    localparam logic [31:0] A_D0  = 32'h1001_0000;
    localparam logic [31:0] A_D1  = 32'h1001_0004;
    localparam logic [31:0] A_D2  = 32'h1001_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_wren = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } memExp_t;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } ackExp_t;

    memExp_t memExp[$];
    ackExp_t ifExp[$];
    ackExp_t dmExp[$];

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    logic [31:0] memArr [32];
    logic [31:0] ifSeq [4];
    logic [31:0] dmAddrSeq [4];
    logic        dmWrenSeq [4];
    logic [31:0] dmDataSeq [4];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_wren(dm_wren), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Small memory model: the chosen address bits keep every test address distinct.
    function automatic logic [4:0] memIdx(input logic [31:0] a);
        return {a[28], a[22], a[4:2]};
    endfunction

    assign mem_rdata = memArr[memIdx(mem_addr)];

    always @(posedge clk) begin
        if (mem_en && mem_wren) memArr[memIdx(mem_addr)] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_ctl"}, {60'd0, if_ack, dm_ack, mem_en, mem_wren}, 64'd0);
        checkOutput({name, "_memAddr"}, {32'd0, mem_addr}, 64'd0);
        checkOutput({name, "_memWdata"}, {32'd0, mem_wdata}, 64'd0);
        checkOutput({name, "_ifRdata"}, {32'd0, if_rdata}, 64'd0);
        checkOutput({name, "_dmRdata"}, {32'd0, dm_rdata}, 64'd0);
    endtask

    task automatic expMem(input logic wren, input logic [31:0] addr, input logic [31:0] wdata, input int c);
        memExp_t e;
        e.wren = wren; e.addr = addr; e.wdata = wdata; e.cyc = c;
        memExp.push_back(e);
    endtask

    task automatic expAck(input logic isDm, input logic [31:0] rdata, input int c);
        ackExp_t e;
        e.rdata = rdata; e.cyc = c;
        if (isDm) dmExp.push_back(e);
        else ifExp.push_back(e);
    endtask

    task automatic waitAck(input logic isDm);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (isDm ? dm_ack : if_ack) return;
        end
        if (isDm) checkOutput("dmAckTimeout", {63'd0, dm_ack}, 64'd1);
        else checkOutput("ifAckTimeout", {63'd0, if_ack}, 64'd1);
    endtask

    // Requesters keep req high across acks while they still have work queued.
    task automatic runIf(input int n);
        for (int i = 0; i < n; i++) begin
            if_addr = ifSeq[i];
            if_req  = 1'b1;
            waitAck(1'b0);
        end
        if_req = 1'b0;
    endtask

    task automatic runDm(input int n);
        for (int i = 0; i < n; i++) begin
            dm_addr  = dmAddrSeq[i];
            dm_wren  = dmWrenSeq[i];
            dm_wdata = dmDataSeq[i];
            dm_req   = 1'b1;
            waitAck(1'b1);
        end
        dm_req  = 1'b0;
        dm_wren = 1'b0;
    endtask

    // Monitor: every mem_en cycle and every ack must match the head of its queue.
    always @(negedge clk) begin : monitor
        memExp_t m;
        ackExp_t a;
        if (mem_en) begin
            if (memExp.size() == 0) begin
                checkOutput("memEnUnexpected", {63'd0, mem_en}, 64'd0);
            end else begin
                m = memExp.pop_front();
                checkOutput("memEnCycle", 64'(cyc), 64'(m.cyc));
                checkOutput("memWren", {63'd0, mem_wren}, {63'd0, m.wren});
                checkOutput("memAddr", {32'd0, mem_addr}, {32'd0, m.addr});
                if (m.wren) checkOutput("memWdata", {32'd0, mem_wdata}, {32'd0, m.wdata});
            end
        end else if (mem_wren) begin
            checkOutput("memWrenWithoutEn", {63'd0, mem_wren}, 64'd0);
        end
        if (if_ack) begin
            if (ifExp.size() == 0) begin
                checkOutput("ifAckUnexpected", {63'd0, if_ack}, 64'd0);
            end else begin
                a = ifExp.pop_front();
                checkOutput("ifAckCycle", 64'(cyc), 64'(a.cyc));
                checkOutput("ifRdata", {32'd0, if_rdata}, {32'd0, a.rdata});
            end
        end
        if (dm_ack) begin
            if (dmExp.size() == 0) begin
                checkOutput("dmAckUnexpected", {63'd0, dm_ack}, 64'd0);
            end else begin
                a = dmExp.pop_front();
                checkOutput("dmAckCycle", 64'(cyc), 64'(a.cyc));
                checkOutput("dmRdata", {32'd0, dm_rdata}, {32'd0, a.rdata});
            end
        end
    end

    task automatic applyStimulus();
        int s;
        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        checkIdle("inReset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkIdle("idle");
        end

        // Conflict straight after reset: DM first, then IF.
        s = cyc + 1;
        ifSeq[0] = A_IF0;
        dmAddrSeq[0] = A_D1; dmWrenSeq[0] = 1'b0; dmDataSeq[0] = 32'h0;
        expMem(1'b0, A_D1, 32'h0, s);
        expAck(1'b1, 32'h0000_CAFE, s + 2);
        expMem(1'b0, A_IF0, 32'h0, s + 4);
        expAck(1'b0, 32'h8C08_0004, s + 6);
        fork
            runIf(1);
            runDm(1);
        join

        // Repeat raised in the DONE cycle: sampled one cycle later, last=IF so DM again.
        s = cyc + 2;
        ifSeq[0] = A_IF1;
        dmAddrSeq[0] = A_D2;
        expMem(1'b0, A_D2, 32'h0, s);
        expAck(1'b1, 32'h1234_5678, s + 2);
        expMem(1'b0, A_IF1, 32'h0, s + 4);
        expAck(1'b0, 32'h2409_0001, s + 6);
        fork
            runIf(1);
            runDm(1);
        join
        @(negedge clk);
        checkOutput("dmRdataHeld", {32'd0, dm_rdata}, 64'h1234_5678);

        // Single fetch.
        s = cyc + 1;
        ifSeq[0] = A_IF0;
        expMem(1'b0, A_IF0, 32'h0, s);
        expAck(1'b0, 32'h8C08_0004, s + 2);
        runIf(1);
        @(negedge clk);

        // Single store keeps dm_rdata, then a load reads the stored word back.
        s = cyc + 1;
        dmAddrSeq[0] = A_D0; dmWrenSeq[0] = 1'b1; dmDataSeq[0] = 32'hDEAD_BEEF;
        expMem(1'b1, A_D0, 32'hDEAD_BEEF, s);
        expAck(1'b1, 32'h1234_5678, s + 2);
        runDm(1);
        @(negedge clk);
        s = cyc + 1;
        dmAddrSeq[0] = A_D0; dmWrenSeq[0] = 1'b0; dmDataSeq[0] = 32'h0;
        expMem(1'b0, A_D0, 32'h0, s);
        expAck(1'b1, 32'hDEAD_BEEF, s + 2);
        runDm(1);
        @(negedge clk);

        // Continuous DM traffic against IF must alternate DM, IF, DM, IF.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s = cyc + 1;
        ifSeq[0] = A_IF1; ifSeq[1] = A_IF2;
        dmAddrSeq[0] = A_D1; dmWrenSeq[0] = 1'b0; dmDataSeq[0] = 32'h0;
        dmAddrSeq[1] = A_D2; dmWrenSeq[1] = 1'b0; dmDataSeq[1] = 32'h0;
        expMem(1'b0, A_D1, 32'h0, s);
        expAck(1'b1, 32'h0000_CAFE, s + 2);
        expMem(1'b0, A_IF1, 32'h0, s + 4);
        expAck(1'b0, 32'h2409_0001, s + 6);
        expMem(1'b0, A_D2, 32'h0, s + 8);
        expAck(1'b1, 32'h1234_5678, s + 10);
        expMem(1'b0, A_IF2, 32'h0, s + 12);
        expAck(1'b0, 32'h012A_5820, s + 14);
        fork
            runIf(2);
            runDm(2);
        join
        @(negedge clk);

        // Reset in the second cycle of a load abandons it without an ack.
        s = cyc + 1;
        expMem(1'b0, A_D1, 32'h0, s);
        dm_addr = A_D1; dm_wren = 1'b0; dm_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dm_req = 1'b0;
        #1;
        checkOutput("midRstMemEn", {63'd0, mem_en}, 64'd0);
        checkOutput("midRstDmAck", {63'd0, dm_ack}, 64'd0);
        checkOutput("midRstDmRdata", {32'd0, dm_rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        s = cyc + 1;
        dmAddrSeq[0] = A_D1; dmWrenSeq[0] = 1'b0; dmDataSeq[0] = 32'h0;
        expMem(1'b0, A_D1, 32'h0, s);
        expAck(1'b1, 32'h0000_CAFE, s + 2);
        runDm(1);
        repeat (3) @(negedge clk);

        checkOutput("memQueueDrained", 64'(memExp.size()), 64'd0);
        checkOutput("ifQueueDrained", 64'(ifExp.size()), 64'd0);
        checkOutput("dmQueueDrained", 64'(dmExp.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) memArr[i] = 32'h0;
        memArr[memIdx(A_IF0)] = 32'h8C08_0004;
        memArr[memIdx(A_IF1)] = 32'h2409_0001;
        memArr[memIdx(A_IF2)] = 32'h012A_5820;
        memArr[memIdx(A_D1)]  = 32'h0000_CAFE;
        memArr[memIdx(A_D2)]  = 32'h1234_5678;
        applyStimulus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single-port memory between instruction fetch (IF) and the load/store data port (DM). Each port issues one request, is serviced as a single non-overlapped memory transaction, and receives a one-cycle acknowledge with read data. When both ports request in the same cycle, a round-robin grant decides which is served first. The block sits between the decoder/PC datapath and the memory macro, and gives the datapath a stall point: it may not proceed until `if_ack` / `dm_ack`.

## Interface
- `ADDR_W`, 32, address width for both ports and memory.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range is 1..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched instruction; valid in the `if_ack` cycle and held until the next IF completion.
- `if_ack`  out  1  one-cycle completion pulse.
- `dm_req`  in  1  data request; held high until `dm_ack`.
- `dm_wren`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_rdata`  out  DATA_W  load data; valid in the `dm_ack` cycle and held.
- `dm_ack`  out  1  one-cycle completion pulse.
- `mem_en`  out  1  memory access strobe, one cycle per transaction.
- `mem_wren`  out  1  memory write enable; only ever high together with `mem_en`.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. A 3-bit counter `cnt` tracks latency, a register `owner` records the served port (IF/DM), and a register `last` records the last granted port.
- **IDLE:** grant is evaluated on every edge.
  - Only `dm_req` high: grant DM.
  - Only `if_req` high: grant IF.
  - Both high: grant the port not equal to `last`.
  - On a grant edge:
    - Register the owner's address into `mem_addr`.
    - For DM, register `dm_wdata` into `mem_wdata` and `dm_wren` into `mem_wren`. For IF, `mem_wren` is 0.
    - Set `mem_en` to 1, `cnt` to `MEM_LAT`, `owner` and `last` to the granted port.
    - Go to ACCESS.
- **ACCESS:**
  - `mem_en` and `mem_wren` fall after the first ACCESS cycle.
  - `cnt` decrements each cycle.
  - On the edge where `cnt` equals 1:
    - Capture `mem_rdata` into the owner's rdata register. Stores do not update `dm_rdata`.
    - Assert the owner's ack for one cycle and go to DONE.
- **DONE:**
  - The ack is high.
  - No grant is made in this cycle, so a requester that drops `req` at this edge is never re-served.
  - Next state is IDLE.
- `mem_addr` and `mem_wdata` hold their values after the transaction. IF and DM requests are never served concurrently.
- A request raised while the other port is being served waits in IDLE arbitration. Combined with round-robin, each port waits at most one foreign transaction.

## Timing
- Reset values (asynchronous, immediate):
  - State is IDLE and `last` is IF, so the first conflict goes to DM.
  - `cnt` = 0.
  - All outputs are 0: `if_ack`, `dm_ack`, `mem_en`, `mem_wren`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`.
- Latency:
  - A request sampled high at edge k puts `mem_en` high in cycle k+1.
  - `mem_rdata` is sampled at edge k+MEM_LAT.
  - Ack is high in cycle k+MEM_LAT+1.
  - Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Reset mid-transaction: the transaction is abandoned, no ack is produced, and `mem_en`/`mem_wren` drop immediately.
- Protocol violation: if a requester drops `req` before ack, the transaction still completes and the ack is still pulsed.
- Simultaneous events:
  - A request arriving in the DONE cycle is sampled in the following IDLE cycle.
  - A DM store and an IF fetch to the same address in the same cycle are ordered by round-robin; no forwarding is done.

## Test plan
- **Reset values:** reset, release, no requests -> all outputs 0 for 10 cycles; `mem_en` never pulses.
- **Single fetch:** `MEM_LAT`=2; `if_req`=1, `if_addr`=0x00400000 sampled at edge 0; memory returns 0x8C080004 -> `mem_en`=1, `mem_wren`=0, `mem_addr`=0x00400000 in cycle 1; `if_ack`=1 and `if_rdata`=0x8C080004 in cycle 3.
- **Single store:** `dm_req`=1, `dm_wren`=1, `dm_addr`=0x10010000, `dm_wdata`=0xDEADBEEF -> one cycle with `mem_en`=`mem_wren`=1 and matching addr/data; `dm_ack` in cycle 3; `dm_rdata` unchanged.
- **Conflict ordering:** `if_req` and `dm_req` high together from reset, each dropping only after its ack -> DM served first (ack cycle 3), IF `mem_en` in cycle 5 and ack in cycle 7. Repeating the conflict immediately with `last`=IF -> DM granted again.
- **No starvation:** `dm_req` held continuously with a new request after every ack, `if_req` high -> grants alternate DM, IF, DM, IF; IF ack within 8 cycles.
- **Mid-transaction reset:** assert `rst` in cycle 2 of a load -> `mem_en`, `dm_ack` and `dm_rdata` are 0, no ack after release, and the next request is serviced with normal latency.
